// File: rtl/aabb_overlap_check.sv
// aabb_overlap_check: decides whether two single-precision AABBs intersect.
// Each box is six words: xmin, xmax, ymin, ymax, zmin, zmax. One axis is
// evaluated per cycle with a sign-magnitude integer compare, so no float
// arithmetic is needed. Handshake is stb/ack on one input and one output channel.
module aabb_overlap_check #(
  parameter bit EARLY_EXIT       = 1'b1,
  parameter bit TOUCH_IS_OVERLAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  input  logic [31:0] a5,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [31:0] b2,
  input  logic [31:0] b3,
  input  logic [31:0] b4,
  input  logic [31:0] b5,
  input  logic        input_stb,
  output logic        input_ack,
  output logic        overlap,
  output logic        nan_flag,
  output logic [1:0]  fail_axis,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  axis_reg;
  logic        overlap_reg;
  logic        nan_reg;
  logic [1:0]  fail_axis_reg;
  logic        stb_reg;
  logic [31:0] a_reg [6];
  logic [31:0] b_reg [6];
  logic [31:0] a_in  [6];
  logic [31:0] b_in  [6];

  // Words of the axis currently being evaluated.
  logic [31:0] amin, amax, bmin, bmax;
  logic        axis_nan;
  logic        axis_fail;

  assign a_in = '{a0, a1, a2, a3, a4, a5};
  assign b_in = '{b0, b1, b2, b3, b4, b5};

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // Map a float onto a signed integer with the same ordering. Both zeros map
  // to 0, negatives become the negated magnitude (so larger magnitude sorts lower).
  function automatic logic signed [31:0] order_key(input logic [31:0] w);
    logic signed [31:0] mag;
    mag = {1'b0, w[30:0]};
    return w[31] ? -mag : mag;
  endfunction

  // Ordered compare x <= y (touching counts) or x < y (strict).
  function automatic logic fcmp(input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] kx, ky;
    kx = order_key(x);
    ky = order_key(y);
    return TOUCH_IS_OVERLAP ? (kx <= ky) : (kx < ky);
  endfunction

  // Select the latched min/max words for the current axis and judge it.
  always_comb begin
    amin = a_reg[0];
    amax = a_reg[1];
    bmin = b_reg[0];
    bmax = b_reg[1];
    case (axis_reg)
      2'd1: begin
        amin = a_reg[2]; amax = a_reg[3]; bmin = b_reg[2]; bmax = b_reg[3];
      end
      2'd2: begin
        amin = a_reg[4]; amax = a_reg[5]; bmin = b_reg[4]; bmax = b_reg[5];
      end
      default: ;
    endcase
    axis_nan  = is_nan(amin) | is_nan(amax) | is_nan(bmin) | is_nan(bmax);
    axis_fail = axis_nan | !(fcmp(amin, bmax) && fcmp(bmin, amax));
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      stb_reg       <= 1'b0;
      overlap_reg   <= 1'b0;
      nan_reg       <= 1'b0;
      fail_axis_reg <= 2'd3;
      axis_reg      <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (input_stb) begin
            for (int i = 0; i < 6; i++) begin
              a_reg[i] <= a_in[i];
              b_reg[i] <= b_in[i];
            end
            axis_reg      <= 2'd0;
            nan_reg       <= 1'b0;
            fail_axis_reg <= 2'd3;
            overlap_reg   <= 1'b0;
            state_reg     <= CMP;
          end
        end
        CMP: begin
          if (axis_nan) nan_reg <= 1'b1;
          // Only the first failing axis is recorded.
          if (axis_fail && (fail_axis_reg == 2'd3)) fail_axis_reg <= axis_reg;
          if ((axis_fail && EARLY_EXIT) || (axis_reg == 2'd2)) begin
            overlap_reg <= !axis_fail && (fail_axis_reg == 2'd3);
            stb_reg     <= 1'b1;
            state_reg   <= DONE;
          end else begin
            axis_reg <= axis_reg + 2'd1;
          end
        end
        DONE: begin
          if (output_z_ack) begin
            stb_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign input_ack    = !rst && (state_reg == IDLE);
  assign overlap      = overlap_reg;
  assign nan_flag     = nan_reg;
  assign fail_axis    = fail_axis_reg;
  assign output_z_stb = stb_reg;

endmodule

// File: tb/tb_aabb_overlap_check.sv
// Bench for aabb_overlap_check: three instances share the stimulus,
// covering the default build, EARLY_EXIT=0 and TOUCH_IS_OVERLAP=0.
module tb_aabb_overlap_check;

  localparam logic [31:0] P0   = 32'h00000000;
  localparam logic [31:0] P1   = 32'h3F800000;
  localparam logic [31:0] P2   = 32'h40000000;
  localparam logic [31:0] P3   = 32'h40400000;
  localparam logic [31:0] N0   = 32'h80000000;
  localparam logic [31:0] NM1  = 32'hBF800000;
  localparam logic [31:0] NM2  = 32'hC0000000;
  localparam logic [31:0] NMH  = 32'hBF000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic       ov;
    logic       nan;
    logic [1:0] fa;
    logic [3:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        input_stb = 1'b0;
  logic [31:0] aw [6];
  logic [31:0] bw [6];
  logic [2:0]  ack_v = 3'b000;
  logic [2:0]  iack_v, stb_v, ov_v, nan_v;
  logic [1:0]  fa_v [3];

  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aabb_overlap_check #(
      .EARLY_EXIT      (gi == 1 ? 1'b0 : 1'b1),
      .TOUCH_IS_OVERLAP(gi == 2 ? 1'b0 : 1'b1)
    ) dut (
      .clk(clk), .rst(rst),
      .a0(aw[0]), .a1(aw[1]), .a2(aw[2]), .a3(aw[3]), .a4(aw[4]), .a5(aw[5]),
      .b0(bw[0]), .b1(bw[1]), .b2(bw[2]), .b3(bw[3]), .b4(bw[4]), .b5(bw[5]),
      .input_stb(input_stb), .input_ack(iack_v[gi]),
      .overlap(ov_v[gi]), .nan_flag(nan_v[gi]), .fail_axis(fa_v[gi]),
      .output_z_stb(stb_v[gi]), .output_z_ack(ack_v[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic ov, input logic nan, input logic [1:0] fa, input logic [3:0] lat);
    exp_t e;
    e.ov = ov; e.nan = nan; e.fa = fa; e.lat = lat;
    return e;
  endfunction

  task automatic set_axis(input int k, input logic [31:0] amn, input logic [31:0] amx,
                          input logic [31:0] bmn, input logic [31:0] bmx);
    aw[2*k] = amn; aw[2*k+1] = amx; bw[2*k] = bmn; bw[2*k+1] = bmx;
  endtask

  // A=[0,2]^3, B=[1,3]^3
  task automatic set_std();
    for (int k = 0; k < 3; k++) set_axis(k, P0, P2, P1, P3);
  endtask

  task automatic expect3(input exp_t e0, input exp_t e1, input exp_t e2);
    q0.push_back(e0); q1.push_back(e1); q2.push_back(e2);
  endtask

  task automatic send(input string name);
    @(negedge clk);
    input_stb = 1'b1;
    @(posedge clk);
    #1;
    input_stb = 1'b0;
    $display("send %s", name);
  endtask

  // Wait for all three results, measure latency from the transfer edge, compare.
  task automatic collect(input string name);
    int   lat [3];
    exp_t e;
    bit   have;
    lat = '{0, 0, 0};
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (lat[k] == 0 && stb_v[k]) lat[k] = n;
      if (stb_v == 3'b111) break;
    end
    for (int k = 0; k < 3; k++) begin
      have = 1'b1;
      case (k)
        0: if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
        1: if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
        default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
      endcase
      if (!have) begin
        check($sformatf("%s_d%0d_queue", name, k), 32'd0, 32'd1);
      end else begin
        check($sformatf("%s_d%0d_lat", name, k), lat[k], {28'd0, e.lat});
        check($sformatf("%s_d%0d_ov", name, k), ov_v[k], e.ov);
        check($sformatf("%s_d%0d_nan", name, k), nan_v[k], e.nan);
        check($sformatf("%s_d%0d_fa", name, k), fa_v[k], e.fa);
        $display("result %s dut%0d lat=%0d ov=%b nan=%b fa=%0d", name, k, lat[k], ov_v[k], nan_v[k], fa_v[k]);
      end
    end
  endtask

  task automatic ack_all(input string name);
    @(negedge clk);
    ack_v = 3'b111;
    @(posedge clk);
    #1;
    ack_v = 3'b000;
    check({name, "_stb_after_ack"}, stb_v, 3'b000);
    check({name, "_iack_after_ack"}, iack_v, 3'b111);
  endtask

  task automatic pair(input string name);
    send(name);
    collect(name);
    ack_all(name);
  endtask

  initial begin
    set_std();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_iack_low", iack_v, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_iack", iack_v, 3'b111);
    check("rst_stb", stb_v, 3'b000);
    check("rst_ov", ov_v, 3'b000);
    check("rst_nan", nan_v, 3'b000);
    for (int k = 0; k < 3; k++) check($sformatf("rst_fa%0d", k), fa_v[k], 2'd3);

    // Overlapping cubes
    set_std();
    expect3(mk(1, 0, 3, 3), mk(1, 0, 3, 3), mk(1, 0, 3, 3));
    pair("cubes");

    // Separated on x
    set_std(); set_axis(0, P0, P1, P2, P3);
    expect3(mk(0, 0, 0, 1), mk(0, 0, 0, 3), mk(0, 0, 0, 1));
    pair("sep_x");

    // Touching on x and across -0/+0 on y
    set_std(); set_axis(0, P0, P1, P1, P3); set_axis(1, NM1, N0, P0, P3);
    expect3(mk(1, 0, 3, 3), mk(1, 0, 3, 3), mk(0, 0, 0, 1));
    pair("touch");

    // Negative x interval passes
    set_std(); set_axis(0, NM1, P1, NM2, NMH);
    expect3(mk(1, 0, 3, 3), mk(1, 0, 3, 3), mk(1, 0, 3, 3));
    pair("neg_x");

    // NaN on B ymax with x passing
    set_std(); set_axis(0, NM1, P1, NM2, NMH); bw[3] = QNAN;
    expect3(mk(0, 1, 1, 2), mk(0, 1, 1, 3), mk(0, 1, 1, 2));
    pair("nan_y");

    // x fails first; NaN on y only reached without early exit
    set_std(); set_axis(0, P0, P1, P2, P3); bw[3] = QNAN;
    expect3(mk(0, 0, 0, 1), mk(0, 1, 0, 3), mk(0, 0, 0, 1));
    pair("sepx_nany");

    // Only z separated
    set_std(); set_axis(2, P2, P3, P0, P1);
    expect3(mk(0, 0, 2, 3), mk(0, 0, 2, 3), mk(0, 0, 2, 3));
    pair("sep_z");

    // Backpressure: hold results while new pairs are offered
    set_std(); bw[3] = QNAN;
    expect3(mk(0, 1, 1, 2), mk(0, 1, 1, 3), mk(0, 1, 1, 2));
    send("bp");
    collect("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      input_stb = 1'b1;
      aw[0] = $urandom; bw[1] = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("bp_stb_c%0d", c), stb_v, 3'b111);
      check($sformatf("bp_iack_c%0d", c), iack_v, 3'b000);
      check($sformatf("bp_ov_c%0d", c), ov_v, 3'b000);
      check($sformatf("bp_nan_c%0d", c), nan_v, 3'b111);
      check($sformatf("bp_fa0_c%0d", c), fa_v[0], 2'd1);
    end
    input_stb = 1'b0;
    ack_all("bp");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_no_spurious_c%0d", c), stb_v, 3'b000);
    end

    // Reset while evaluating axis 1
    set_std();
    send("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_iack_low", iack_v, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_stb", stb_v, 3'b000);
    check("rstmid_ov", ov_v, 3'b000);
    check("rstmid_iack", iack_v, 3'b111);
    for (int k = 0; k < 3; k++) check($sformatf("rstmid_fa%0d", k), fa_v[k], 2'd3);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstmid_quiet_c%0d", c), stb_v, 3'b000);
    end

    // Next pair after reset processes normally
    set_std(); set_axis(0, NM1, P1, NM2, NMH);
    expect3(mk(1, 0, 3, 3), mk(1, 0, 3, 3), mk(1, 0, 3, 3));
    pair("after_rst");

    check("queues_empty", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
